// File: rtl/arinc429_pkg.sv
// Shared ARINC 429 word definitions.
// Used by the RX arbiter and the TX/RX word datapaths.
// The word type packs an 8-bit label above a 23-bit data field.
package arinc429_pkg;

  localparam int ADR_W = 8;
  localparam int DAT_W = 23;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } a429_word_t;

endpackage

// File: rtl/arinc429_word_fifo.sv
// First-word-fall-through FIFO with a registered head word and an occupancy count.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   push, din   write strobe and word; the caller never pushes when the FIFO is full
//               unless it pops in the same cycle
//   pop         consumer ready; the head word is taken only while valid=1
//   dout        registered head word; it is zero out of reset
//   valid       the head word is present
//   cnt         words held, counting the head word
module arinc429_word_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             valid,
  output logic [CNT_W-1:0] cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CNT_W-1:0] remain, cnt_next;
  logic             do_pop;

  // NOTE: every always_comb output is assigned at the top of the block, on
  // every path, so no latch can be inferred.
  always_comb begin
    do_pop   = pop & valid;
    rd_next  = rd_ptr + PTR_W'(do_pop);   // DEPTH is a power of two, so the add wraps on its own
    remain   = cnt - CNT_W'(do_pop);      // words left after this cycle's pop
    cnt_next = remain + CNT_W'(push);
  end

  // NOTE: the storage array has no reset. Words are only reachable through the
  // pointers and the count, and those are reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // NOTE: registers are updated with non-blocking assignments, so every read in
  // this block sees the value from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      cnt    <= cnt_next;
      rd_ptr <= rd_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      valid  <= (cnt_next != '0);
      // The head register reloads from the next read slot. If nothing else is
      // stored, it loads the word being pushed, which bypasses the array read.
      if (cnt_next != '0)
        dout <= (push && remain == '0) ? din : mem[rd_next];
    end
  end

endmodule

// File: rtl/arinc429_rx_arbiter.sv
// Multi-channel ARINC 429 receive-word arbiter.
// NCH receiver channels each capture into a holding register. Pending channels
// are granted round-robin, one per cycle, into a shared FWFT word FIFO.
//
// Ports:
//   GCLK, reset        clock and asynchronous active-low reset
//   ch_adr/ch_dat      per-channel label/data; channel k sits at slot k of each bus
//   ch_ce, ch_en       per-channel word strobe and enable mask
//   ovf_clr            per-channel clear for the sticky overflow flag
//   sr_adr/sr_dat/sr_ch head-of-FIFO word and the channel it came from
//   out_valid/out_ready head handshake
//   ovf                sticky per-channel overflow flags
//   fifo_cnt           FIFO occupancy
module arinc429_rx_arbiter
  import arinc429_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DEPTH = 8,
  parameter int CH_W  = $clog2(NCH)
) (
  input  logic                     GCLK,
  input  logic                     reset,
  input  logic [NCH*ADR_W-1:0]     ch_adr,
  input  logic [NCH*DAT_W-1:0]     ch_dat,
  input  logic [NCH-1:0]           ch_ce,
  input  logic [NCH-1:0]           ch_en,
  input  logic [NCH-1:0]           ovf_clr,
  output logic [ADR_W-1:0]         sr_adr,
  output logic [DAT_W-1:0]         sr_dat,
  output logic [CH_W-1:0]          sr_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NCH-1:0]           ovf,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    a429_word_t      word;
    logic [CH_W-1:0] ch;
  } entry_t;

  a429_word_t      hold [NCH];
  logic [NCH-1:0]  pend, cap, cap_ok, ovf_set, grant_vec;
  logic [CH_W-1:0] rr_ptr, grant_idx;
  logic            grant_any, space, pop;
  entry_t          push_entry, head;

  always_comb begin
    cap   = ch_ce & ch_en;
    pop   = out_valid & out_ready;
    // A pop in this cycle frees a slot even when the FIFO is full.
    space = (fifo_cnt < CNT_W'(DEPTH)) || pop;

    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (space && !grant_any && pend[(int'(rr_ptr) + i) % NCH]) begin
        grant_any = 1'b1;
        grant_idx = CH_W'((int'(rr_ptr) + i) % NCH);
      end
    end
    grant_vec = '0;
    if (grant_any) grant_vec[grant_idx] = 1'b1;

    // A granted channel empties its holding register this cycle, so a new
    // strobe on it can be captured. A pending, ungranted channel drops the strobe.
    cap_ok  = cap & (~pend | grant_vec);
    ovf_set = cap & pend & ~grant_vec;

    push_entry = '{word: hold[grant_idx], ch: grant_idx};
  end

  always_ff @(posedge GCLK) begin
    for (int k = 0; k < NCH; k++) begin
      if (cap_ok[k])
        hold[k] <= '{adr: ch_adr[k*ADR_W +: ADR_W], dat: ch_dat[k*DAT_W +: DAT_W]};
    end
  end

  always_ff @(posedge GCLK or negedge reset) begin
    if (!reset) begin
      pend   <= '0;
      ovf    <= '0;
      rr_ptr <= '0;
    end else begin
      pend <= cap_ok | (pend & ~grant_vec);
      ovf  <= (ovf & ~ovf_clr) | ovf_set;   // set wins over clear
      if (grant_any)
        rr_ptr <= (grant_idx == CH_W'(NCH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  arinc429_word_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (GCLK),
    .rst_n (reset),
    .push  (grant_any),
    .din   (push_entry),
    .pop   (out_ready),
    .dout  (head),
    .valid (out_valid),
    .cnt   (fifo_cnt)
  );

  assign sr_adr = head.word.adr;
  assign sr_dat = head.word.dat;
  assign sr_ch  = head.ch;

endmodule

// File: tb/tb_arinc429_rx_arbiter.sv
// Directed bench for arinc429_rx_arbiter with NCH=4 and DEPTH=8.
module tb_arinc429_rx_arbiter;

  localparam int NCH = 4;
  localparam int DEPTH = 8;

  logic          GCLK;
  logic          reset;
  logic [31:0]   ch_adr;
  logic [91:0]   ch_dat;
  logic [3:0]    ch_ce, ch_en, ovf_clr, ovf;
  logic [7:0]    sr_adr;
  logic [22:0]   sr_dat;
  logic [1:0]    sr_ch;
  logic          out_valid, out_ready;
  logic [3:0]    fifo_cnt;

  int tests = 0;
  int fails = 0;

  arinc429_rx_arbiter #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .GCLK      (GCLK),
    .reset     (reset),
    .ch_adr    (ch_adr),
    .ch_dat    (ch_dat),
    .ch_ce     (ch_ce),
    .ch_en     (ch_en),
    .ovf_clr   (ovf_clr),
    .sr_adr    (sr_adr),
    .sr_dat    (sr_dat),
    .sr_ch     (sr_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf),
    .fifo_cnt  (fifo_cnt)
  );

  initial begin
    GCLK = 1'b0;
    forever #5 GCLK = ~GCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary line");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge GCLK);
    #1;
  endtask

  task automatic set_word(input int k, input logic [7:0] adr, input logic [22:0] dat);
    ch_adr[k*8 +: 8]   = adr;
    ch_dat[k*23 +: 23] = dat;
  endtask

  task automatic check_head(input string name, input logic [7:0] adr, input logic [22:0] dat,
                            input logic [1:0] ch);
    check({name, ".valid"}, 64'(out_valid), 64'd1);
    check({name, ".adr"}, 64'(sr_adr), 64'(adr));
    check({name, ".dat"}, 64'(sr_dat), 64'(dat));
    check({name, ".ch"}, 64'(sr_ch), 64'(ch));
  endtask

  typedef struct {
    int          ch;
    logic [7:0]  adr;
    logic [22:0] dat;
    logic [1:0]  exp_ch;
    logic [7:0]  exp_adr;
    logic [22:0] exp_dat;
  } vec_t;

  vec_t vecs [4];

  logic [7:0]  exp_adr_q [10];
  logic [22:0] exp_dat_q [10];
  logic [1:0]  exp_ch_q  [10];

  initial begin
    // Single-word vectors. The last one is on channel 0, which leaves rr_ptr=1.
    vecs[0] = '{ch: 3, adr: 8'h33, dat: 23'h000333, exp_ch: 2'd3, exp_adr: 8'h33, exp_dat: 23'h000333};
    vecs[1] = '{ch: 2, adr: 8'h5A, dat: 23'h123456, exp_ch: 2'd2, exp_adr: 8'h5A, exp_dat: 23'h123456};
    vecs[2] = '{ch: 1, adr: 8'hFF, dat: 23'h7FFFFF, exp_ch: 2'd1, exp_adr: 8'hFF, exp_dat: 23'h7FFFFF};
    vecs[3] = '{ch: 0, adr: 8'h01, dat: 23'h400001, exp_ch: 2'd0, exp_adr: 8'h01, exp_dat: 23'h400001};

    ch_adr = '0; ch_dat = '0; ch_ce = '0; ch_en = '1; ovf_clr = '0; out_ready = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.adr", 64'(sr_adr), 64'd0);
    check("rst.dat", 64'(sr_dat), 64'd0);
    check("rst.ch", 64'(sr_ch), 64'd0);
    check("rst.ovf", 64'(ovf), 64'd0);
    check("rst.cnt", 64'(fifo_cnt), 64'd0);
    @(posedge GCLK);
    @(posedge GCLK);
    #1 reset = 1'b1;

    // Uncontended path: strobe at t, nothing at t+1, head word at t+2, empty after the pop.
    for (int v = 0; v < 4; v++) begin
      set_word(vecs[v].ch, vecs[v].adr, vecs[v].dat);
      ch_ce = '0;
      ch_ce[vecs[v].ch] = 1'b1;
      step();
      ch_ce = '0;
      check($sformatf("vec%0d.t1_valid", v), 64'(out_valid), 64'd0);
      step();
      check_head($sformatf("vec%0d", v), vecs[v].exp_adr, vecs[v].exp_dat, vecs[v].exp_ch);
      check($sformatf("vec%0d.cnt1", v), 64'(fifo_cnt), 64'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check($sformatf("vec%0d.drained_valid", v), 64'(out_valid), 64'd0);
      check($sformatf("vec%0d.drained_cnt", v), 64'(fifo_cnt), 64'd0);
    end

    // All four channels strobe together with rr_ptr=1. Expected output order is 1,2,3,0.
    for (int k = 0; k < 4; k++) set_word(k, 8'h10 + 8'(k), 23'h050000 + 23'(k));
    ch_ce = 4'hF;
    out_ready = 1'b1;
    step();
    ch_ce = '0;
    step();
    check_head("rr.w0", 8'h11, 23'h050001, 2'd1);
    step();
    check_head("rr.w1", 8'h12, 23'h050002, 2'd2);
    step();
    check_head("rr.w2", 8'h13, 23'h050003, 2'd3);
    step();
    check_head("rr.w3", 8'h10, 23'h050000, 2'd0);
    step();
    out_ready = 1'b0;
    check("rr.empty", 64'(out_valid), 64'd0);
    check("rr.ovf", 64'(ovf), 64'd0);

    // Nine staggered strobes on channels 1,2,3,1,... with the consumer stalled.
    // Eight words fill the FIFO and word 8 stays pending on channel 3.
    for (int i = 0; i < 9; i++) begin
      set_word(1 + i % 3, 8'hA0 + 8'(i), 23'h000100 + 23'(i));
      exp_adr_q[i] = 8'hA0 + 8'(i);
      exp_dat_q[i] = 23'h000100 + 23'(i);
      exp_ch_q[i]  = 2'(1 + i % 3);
      ch_ce = '0;
      ch_ce[1 + i % 3] = 1'b1;
      step();
    end
    ch_ce = '0;
    check("full.cnt", 64'(fifo_cnt), 64'd8);
    check_head("full.head", 8'hA0, 23'h000100, 2'd1);

    // Channel 0 strobes twice while the FIFO is full. The first word is held
    // and the second is dropped with an overflow.
    set_word(0, 8'hC0, 23'h0AAAAA);
    exp_adr_q[9] = 8'hC0; exp_dat_q[9] = 23'h0AAAAA; exp_ch_q[9] = 2'd0;
    ch_ce = 4'b0001;
    step();
    check("ovf.first_ok", 64'(ovf), 64'd0);
    set_word(0, 8'hC1, 23'h055555);
    step();
    ch_ce = '0;
    check("ovf.set", 64'(ovf), 64'b0001);
    check("stall.cnt", 64'(fifo_cnt), 64'd8);
    check_head("stall.head", 8'hA0, 23'h000100, 2'd1);
    // An overflow strobe in the same cycle as the clear leaves the flag set.
    set_word(0, 8'hC2, 23'h011111);
    ch_ce = 4'b0001;
    ovf_clr = 4'b0001;
    step();
    ch_ce = '0;
    check("ovf.set_dominant", 64'(ovf), 64'b0001);
    step();
    ovf_clr = '0;
    check("ovf.cleared", 64'(ovf), 64'd0);
    check_head("stall2.head", 8'hA0, 23'h000100, 2'd1);

    // Drain with the consumer ready: arrival order, then channel 0's first word, with no bubbles.
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      check_head($sformatf("drain%0d", j), exp_adr_q[j], exp_dat_q[j], exp_ch_q[j]);
      step();
    end
    out_ready = 1'b0;
    check("drain.empty_valid", 64'(out_valid), 64'd0);
    step();
    check("drain.no_extra", 64'(out_valid), 64'd0);
    check("drain.cnt", 64'(fifo_cnt), 64'd0);

    // A strobe on a disabled channel is ignored.
    ch_en = 4'b0111;
    set_word(3, 8'h77, 23'h000777);
    ch_ce = 4'b1000;
    step();
    ch_ce = '0;
    step();
    step();
    check("dis.valid", 64'(out_valid), 64'd0);
    check("dis.cnt", 64'(fifo_cnt), 64'd0);
    check("dis.ovf3", 64'(ovf[3]), 64'd0);
    ch_en = 4'hF;

    // Burst with rr_ptr=1, then reset asserted mid-burst.
    // The second strobe on every channel overflows, except on channel 1, which is granted in that cycle.
    for (int k = 0; k < 4; k++) set_word(k, 8'hE0 + 8'(k), 23'h0E0000 + 23'(k));
    ch_ce = 4'hF;
    step();
    step();
    ch_ce = '0;
    check("burst.ovf", 64'(ovf), 64'b1101);
    check("burst.cnt", 64'(fifo_cnt), 64'd1);
    check_head("burst.head", 8'hE1, 23'h0E0001, 2'd1);
    step();
    reset = 1'b0;
    #1;
    check("midrst.valid", 64'(out_valid), 64'd0);
    check("midrst.adr", 64'(sr_adr), 64'd0);
    check("midrst.dat", 64'(sr_dat), 64'd0);
    check("midrst.ch", 64'(sr_ch), 64'd0);
    check("midrst.ovf", 64'(ovf), 64'd0);
    check("midrst.cnt", 64'(fifo_cnt), 64'd0);
    step();
    reset = 1'b1;
    step();
    step();
    step();
    check("postrst.valid", 64'(out_valid), 64'd0);
    check("postrst.cnt", 64'(fifo_cnt), 64'd0);
    check("postrst.ovf", 64'(ovf), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arinc429_rx_arbiter.md
# arinc429_rx_arbiter

Parametrised multi-channel ARINC 429 receive-word arbiter. It replaces the fixed two-way receiver select with NCH independent receiver channels. Each channel has its own holding register and a sticky overflow flag. Channels are served round-robin into a shared word FIFO, which is drained through a valid/ready handshake. The block sits between the per-line AR_RXD-class receivers and the host-side word consumer.

## Interface
Parameters:
- NCH, 4: number of receiver channels (2..8)
- DEPTH, 8: output FIFO depth in words (power of two, ≥2)
- CH_W, $clog2(NCH): channel-index width (derived)

Ports:
- GCLK  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- ch_adr  in  NCH*8  per-channel label; channel k occupies bits [8k+7:8k]
- ch_dat  in  NCH*23  per-channel data field; channel k occupies bits [23k+22:23k]
- ch_ce  in  NCH  per-channel one-cycle word-valid strobe from the receivers
- ch_en  in  NCH  channel enable mask; a strobe on a disabled channel is ignored
- ovf_clr  in  NCH  per-channel overflow clear, one cycle, level-sampled
- sr_adr  out  8  head-of-FIFO label
- sr_dat  out  23  head-of-FIFO data
- sr_ch  out  CH_W  source channel of the head word
- out_valid  out  1  head word present
- out_ready  in  1  consumer accepts the head word when out_valid=1
- ovf  out  NCH  sticky per-channel overflow flags
- fifo_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Capture: when ch_ce[k]=1 and ch_en[k]=1, channel k's label and data are loaded into hold[k], and pend[k] is set.
- Overflow: a strobe arrives on a channel where pend[k]=1 and that channel is not granted in the same cycle.
  - The new word is dropped and the old word is kept.
  - ovf[k] is set.
- Capture during grant: a strobe arrives on a channel where pend[k]=1 and that channel is granted in the same cycle.
  - The new word is captured and pend[k] stays set.
  - No overflow is flagged.
- Disabling a channel does not flush it: if pend[k] is already set, the word still drains.
- Arbitration: at most one grant per cycle, made only when space is available.
  - Space means fifo_cnt < DEPTH, or a pop happens in the same cycle (out_valid & out_ready).
  - Priority is round-robin. The search starts at rr_ptr and wraps modulo NCH.
  - After a grant to channel g, rr_ptr becomes (g+1) mod NCH. Without a grant, rr_ptr holds.
- A grant pushes {hold[g], g} into the FIFO and clears pend[g], unless a new capture on g happens in the same cycle.
- FIFO behaviour:
  - First-word-fall-through; sr_adr, sr_dat and sr_ch are registered head outputs.
  - Simultaneous push and pop leaves fifo_cnt unchanged.
  - Pointers wrap modulo DEPTH.
- Flag priority: ovf[k] is set-dominant over ovf_clr[k] in the same cycle.
- Reset values: out_valid=0, sr_adr=0, sr_dat=0, sr_ch=0, ovf=0, fifo_cnt=0, pend=0, rr_ptr=0.
- Reset asserted mid-operation discards all held and queued words immediately (asynchronous).

## Timing
- Uncontended path from strobe to output:
  - Strobe in cycle t sets pend in t+1.
  - The grant and FIFO push happen in t+1.
  - out_valid=1 from t+2.
- Throughput: one word per cycle sustained.
- Worst-case wait for a pending channel: NCH−1 grant cycles while the FIFO has space.
- The head word changes on the cycle after a pop. If the FIFO still holds words, out_valid stays 1 with no bubble.
- FIFO full and no pop: no grant; pend bits hold; further strobes on pending channels set ovf.
- Protocol stability: out_valid must not drop and the head word must not change while out_valid=1 and out_ready=0.

## Structure
- Package arinc429_pkg:
  - ADR_W=8, DAT_W=23.
  - A packed word type {adr, dat}, shared with the TX/RX blocks.
- Sub-module arinc429_word_fifo:
  - Parametrised width (ADR_W+DAT_W+CH_W) and DEPTH.
  - FWFT, with count output.
- Arbiter, holding registers and overflow flags live in the top module.

## Test plan
- Single word, empty FIFO: ch_ce[2] with adr=8'h5A, dat=23'h123456 at t → out_valid at t+2 with sr_adr=5A, sr_dat=123456, sr_ch=2; fifo_cnt returns to 0 after the pop.
- All four channels strobe in the same cycle, rr_ptr=1, out_ready=1 → output order 1,2,3,0 on consecutive cycles, with no overflow.
- Channel 0 strobes twice while the FIFO is full and out_ready=0 → the first word is kept, ovf[0]=1. Raising ovf_clr[0] clears the flag. With out_ready raised, only the first word is delivered.
- DEPTH=8, out_ready=0, nine staggered strobes → fifo_cnt=8, one word still pending. After 9 pops the words arrive in arrival order, pointers wrap correctly, and out_valid stays stable while stalled.
- ch_en[3]=0 and ch_ce[3]=1 → nothing is queued and ovf[3] stays 0. reset pulled low mid-burst → all outputs return to reset values in the same cycle, and no stale word appears after reset is released.
